// File: rtl/intr_trap_ctrl.sv
// External-interrupt trap sequencer: latches IRQ edges, round-robin arbitrates,
// drains the pipeline, then strobes trap entry to csr_regs and sequences MRET exit.
module intr_trap_ctrl #(
    parameter int NUM_SRC   = 8,
    parameter int ID_W      = 3,
    parameter int DRAIN_MAX = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic               mstatus_mie_i,
    input  logic               meie_i,
    input  logic               pipe_idle_i,
    input  logic               mret_i,
    output logic               stall_o,
    output logic               flush_o,
    output logic               e_intr_o,
    output logic               mret_o,
    output logic [NUM_SRC-1:0] irq_ack_o,
    output logic [ID_W-1:0]    claim_id_o,
    output logic               in_trap_o,
    output logic               drain_err_o
);

    localparam int CNT_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        TAKE,
        HANDLER,
        RET
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] grant_oh;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    claim_id;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;
    logic               grant_vld;
    logic [CNT_W-1:0]   drain_cnt;
    logic               drain_err;
    logic               take;

    assign take = (|pend) & mstatus_mie_i & meie_i;

    // Round-robin search starting just after the last granted source, wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = ID_W'((32'(rr_ptr) + 32'(k) + 32'd1) % 32'(NUM_SRC));
            if (!grant_vld && pend[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_oh = (state == TAKE && grant_vld) ? (NUM_SRC'(1) << grant_idx) : '0;

    assign stall_o     = (state == DRAIN) || (state == TAKE);
    assign flush_o     = (state == DRAIN);
    assign e_intr_o    = (state == TAKE) && grant_vld;
    assign mret_o      = (state == RET);
    assign irq_ack_o   = grant_oh;
    assign claim_id_o  = claim_id;
    assign in_trap_o   = (state == TAKE) || (state == HANDLER) || (state == RET);
    assign drain_err_o = drain_err;

    // A fresh edge on the same cycle as its ack keeps the source pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            pend      <= '0;
            irq_q     <= '0;
            rr_ptr    <= ID_W'(NUM_SRC - 1);
            claim_id  <= '0;
            drain_cnt <= '0;
            drain_err <= 1'b0;
        end else begin
            irq_q <= irq_i;
            pend  <= (pend & ~grant_oh) | (irq_i & ~irq_q);
            case (state)
                IDLE: begin
                    if (take) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (!take) begin
                        state <= IDLE;
                    end else if (pipe_idle_i) begin
                        state <= TAKE;
                    end else if (drain_cnt == CNT_W'(DRAIN_MAX - 1)) begin
                        state     <= TAKE;
                        drain_err <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                TAKE: begin
                    if (grant_vld) begin
                        claim_id <= grant_idx;
                        rr_ptr   <= grant_idx;
                        state    <= HANDLER;
                    end else begin
                        state <= IDLE;
                    end
                end
                HANDLER: begin
                    if (mret_i) begin
                        state <= RET;
                    end
                end
                RET: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
